// File: rtl/adam_aes_key_expand.sv
// Iterative AES-128 key schedule.
// Produces one round key per clock from the cipher key. The RotWord of the
// previous round key's last word goes out to an external S-box, and the
// substituted word comes back combinationally in the same cycle. All 11 round
// keys are kept in a register file that the cipher datapath reads by index.
//
// Handshake: start_i is a single-cycle request. It is accepted only in IDLE
// (busy_o=0); while busy_o=1 it is ignored. ready_o=1 means every entry of
// the round key file belongs to the last accepted key. A new accepted start
// drops ready_o on the accepting edge.
module adam_aes_key_expand #(
  parameter int NROUNDS = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         ready_o,
  output logic [31:0]  sboxw_o,
  input  logic [31:0]  new_sboxw_i,
  input  logic [3:0]   round_idx_i,
  output logic [127:0] round_key_o,
  output logic         dbg_state_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_load;
  logic         w_step;
  logic         w_last;

  logic [3:0]   r_ctr;
  logic [7:0]   r_rcon;
  logic         r_busy;
  logic         r_ready;
  logic [127:0] r_rk [0:NROUNDS];

  logic [127:0] w_prev;
  logic [31:0]  w_t;
  logic [31:0]  w_w4;
  logic [31:0]  w_w5;
  logic [31:0]  w_w6;
  logic [31:0]  w_w7;
  logic [7:0]   w_rcon_nxt;

  // Next-state and step decode for the IDLE/EXPAND controller.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_load      = 1'b1;
          w_state_nxt = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        w_step = 1'b1;
        if (r_ctr == 4'(NROUNDS)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Previous round key, guarded so the index never leaves the register file.
  always_comb begin
    w_prev = '0;
    if (r_ctr >= 4'd1 && r_ctr <= 4'(NROUNDS)) begin
      w_prev = r_rk[r_ctr - 4'd1];
    end
  end

  // One key-schedule step: RotWord out, SubWord back in, then the XOR chain.
  always_comb begin
    sboxw_o = '0;
    if (r_state == ST_EXPAND) begin
      sboxw_o = {w_prev[23:0], w_prev[31:24]};
    end
    w_t        = new_sboxw_i ^ {r_rcon, 24'h0};
    w_w4       = w_prev[127:96] ^ w_t;
    w_w5       = w_prev[95:64]  ^ w_w4;
    w_w6       = w_prev[63:32]  ^ w_w5;
    w_w7       = w_prev[31:0]   ^ w_w6;
    w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
  end

  // Controller state, round counter, rcon and status flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_ctr   <= 4'd0;
      r_rcon  <= 8'h01;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_ctr   <= 4'd1;
        r_rcon  <= 8'h01;
        r_busy  <= 1'b1;
        r_ready <= 1'b0;
      end else if (w_step) begin
        r_ctr  <= r_ctr + 4'd1;
        r_rcon <= w_rcon_nxt;
        if (w_last) begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      end
    end
  end

  // Round key register file: cipher key into slot 0, then one slot per step.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i <= NROUNDS; i++) begin
        r_rk[i] <= '0;
      end
    end else begin
      if (w_load) begin
        r_rk[0] <= key_i;
      end else if (w_step) begin
        r_rk[r_ctr] <= {w_w4, w_w5, w_w6, w_w7};
      end
    end
  end

  // Combinational round key read; out-of-range indices read as zero.
  always_comb begin
    round_key_o = '0;
    if (round_idx_i <= 4'(NROUNDS)) begin
      round_key_o = r_rk[round_idx_i];
    end
  end

  assign busy_o      = r_busy;
  assign ready_o     = r_ready;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_adam_aes_key_expand.sv
// Bench for the AES-128 key schedule: directed keys with FIPS-197 reference
// round keys, an S-box model closing the combinational loop, and scenario
// tasks for latency, ignored starts, mid-run reset, bounds and restarts.
module tb_adam_aes_key_expand;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic [127:0] key_i;
  logic         busy_o;
  logic         ready_o;
  logic [31:0]  sboxw_o;
  logic [31:0]  new_sboxw_i;
  logic [3:0]   round_idx_i;
  logic [127:0] round_key_o;
  logic         dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_Z  = 128'h0;

  localparam logic [127:0] RK_A [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  localparam logic [127:0] RK_Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] RK_Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX_TAB[2047 - 8 * int'(b) -: 8];
  endfunction

  // Combinational S-box stage downstream of the key schedule.
  assign new_sboxw_i = {sb(sboxw_o[31:24]), sb(sboxw_o[23:16]),
                        sb(sboxw_o[15:8]),  sb(sboxw_o[7:0])};

  adam_aes_key_expand #(.NROUNDS(10)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start_i),
    .key_i       (key_i),
    .busy_o      (busy_o),
    .ready_o     (ready_o),
    .sboxw_o     (sboxw_o),
    .new_sboxw_i (new_sboxw_i),
    .round_idx_i (round_idx_i),
    .round_key_o (round_key_o),
    .dbg_state_o (dbg_state_o)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: caller is at a negedge; the start is taken on the next posedge
  // and the task returns at the negedge after that edge.
  task automatic do_start(input logic [127:0] k);
    key_i   = k;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Waits (bounded) for ready_o, counting negedges after the start edge.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!ready_o && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic read_rk(input int idx, output logic [127:0] v);
    round_idx_i = 4'(idx);
    #1;
    v = round_key_o;
  endtask

  task automatic test_reset();
    logic [127:0] v;
    n_checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || sboxw_o !== 32'h0 || dbg_state_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b ready=%b sboxw=%h state=%b, required 0 0 00000000 0",
               busy_o, ready_o, sboxw_o, dbg_state_o);
    end
    for (int i = 0; i <= 10; i++) begin
      read_rk(i, v);
      n_checks++;
      if (v !== 128'h0) begin
        n_fail++;
        $display("FAIL reset_rk[%0d]: got %h required 0", i, v);
      end
    end
  endtask

  task automatic test_fips_key();
    int cyc;
    logic [127:0] v;
    do_start(KEY_A);
    n_checks++;
    if (busy_o !== 1'b1 || ready_o !== 1'b0 || dbg_state_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fips_busy_after_start: busy=%b ready=%b state=%b, required 1 0 1",
               busy_o, ready_o, dbg_state_o);
    end
    n_checks++;
    if (sboxw_o !== 32'hcf4f3c09) begin
      n_fail++;
      $display("FAIL fips_sboxw_first: got %h required cf4f3c09", sboxw_o);
    end
    wait_ready(cyc);
    n_checks++;
    if (cyc !== 10) begin
      n_fail++;
      $display("FAIL fips_latency: ready after %0d cycles, required 10", cyc);
    end
    n_checks++;
    if (busy_o !== 1'b0 || sboxw_o !== 32'h0 || dbg_state_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fips_idle_after_done: busy=%b sboxw=%h state=%b, required 0 0 0",
               busy_o, sboxw_o, dbg_state_o);
    end
    for (int i = 0; i <= 10; i++) begin
      read_rk(i, v);
      n_checks++;
      if (v !== RK_A[i]) begin
        n_fail++;
        $display("FAIL fips_rk[%0d]: got %h required %h", i, v, RK_A[i]);
      end
    end
  endtask

  task automatic test_bounds();
    logic [127:0] v;
    for (int i = 11; i <= 15; i++) begin
      read_rk(i, v);
      n_checks++;
      if (v !== 128'h0) begin
        n_fail++;
        $display("FAIL bounds_idx%0d: got %h required 0", i, v);
      end
    end
    read_rk(0, v);
    n_checks++;
    if (v !== KEY_A) begin
      n_fail++;
      $display("FAIL bounds_idx0: got %h required %h", v, KEY_A);
    end
  endtask

  task automatic test_zero_key();
    int cyc;
    logic [127:0] v;
    @(negedge clk);
    do_start(KEY_Z);
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_ready_drop: got %b required 0", ready_o);
    end
    wait_ready(cyc);
    n_checks++;
    if (cyc !== 10) begin
      n_fail++;
      $display("FAIL zero_latency: got %0d required 10", cyc);
    end
    read_rk(0, v);
    n_checks++;
    if (v !== 128'h0) begin
      n_fail++;
      $display("FAIL zero_rk0: got %h required 0", v);
    end
    read_rk(1, v);
    n_checks++;
    if (v !== RK_Z1) begin
      n_fail++;
      $display("FAIL zero_rk1: got %h required %h", v, RK_Z1);
    end
    read_rk(10, v);
    n_checks++;
    if (v !== RK_Z10) begin
      n_fail++;
      $display("FAIL zero_rk10: got %h required %h", v, RK_Z10);
    end
  endtask

  task automatic test_start_during_expand();
    int busy_cnt;
    int rdy_at;
    logic [127:0] v;
    @(negedge clk);
    do_start(KEY_A);
    busy_cnt = int'(busy_o);
    rdy_at   = -1;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) begin
        start_i = 1'b1;
        key_i   = KEY_Z;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      busy_cnt += int'(busy_o);
      if (ready_o && rdy_at < 0) rdy_at = i + 1;
    end
    start_i = 1'b0;
    n_checks++;
    if (busy_cnt !== 10) begin
      n_fail++;
      $display("FAIL ignore_busy_cycles: got %0d required 10", busy_cnt);
    end
    n_checks++;
    if (rdy_at !== 10) begin
      n_fail++;
      $display("FAIL ignore_latency: got %0d required 10", rdy_at);
    end
    for (int i = 0; i <= 10; i++) begin
      read_rk(i, v);
      n_checks++;
      if (v !== RK_A[i]) begin
        n_fail++;
        $display("FAIL ignore_rk[%0d]: got %h required %h", i, v, RK_A[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [127:0] v;
    @(negedge clk);
    do_start(KEY_A);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || sboxw_o !== 32'h0 || dbg_state_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_flags: busy=%b ready=%b sboxw=%h state=%b, required 0 0 0 0",
               busy_o, ready_o, sboxw_o, dbg_state_o);
    end
    for (int i = 0; i <= 10; i++) begin
      round_idx_i = 4'(i);
      #0.1;
      n_checks++;
      if (round_key_o !== 128'h0) begin
        n_fail++;
        $display("FAIL midrst_rk[%0d]: got %h required 0", i, round_key_o);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(KEY_Z);
    wait_ready(cyc);
    n_checks++;
    if (cyc !== 10) begin
      n_fail++;
      $display("FAIL midrst_restart_latency: got %0d required 10", cyc);
    end
    read_rk(1, v);
    n_checks++;
    if (v !== RK_Z1) begin
      n_fail++;
      $display("FAIL midrst_rk1: got %h required %h", v, RK_Z1);
    end
    read_rk(10, v);
    n_checks++;
    if (v !== RK_Z10) begin
      n_fail++;
      $display("FAIL midrst_rk10: got %h required %h", v, RK_Z10);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [127:0] v;
    @(negedge clk);
    do_start(KEY_A);
    wait_ready(cyc);
    n_checks++;
    if (cyc !== 10) begin
      n_fail++;
      $display("FAIL b2b_first_latency: got %0d required 10", cyc);
    end
    do_start(KEY_Z);
    n_checks++;
    if (ready_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_restart_flags: ready=%b busy=%b, required 0 1", ready_o, busy_o);
    end
    wait_ready(cyc);
    n_checks++;
    if (cyc !== 10) begin
      n_fail++;
      $display("FAIL b2b_second_latency: got %0d required 10", cyc);
    end
    read_rk(0, v);
    n_checks++;
    if (v !== KEY_Z) begin
      n_fail++;
      $display("FAIL b2b_rk0: got %h required %h", v, KEY_Z);
    end
    read_rk(1, v);
    n_checks++;
    if (v !== RK_Z1) begin
      n_fail++;
      $display("FAIL b2b_rk1: got %h required %h", v, RK_Z1);
    end
    read_rk(10, v);
    n_checks++;
    if (v !== RK_Z10) begin
      n_fail++;
      $display("FAIL b2b_rk10: got %h required %h", v, RK_Z10);
    end
  endtask

  // Scenario sequence and final report.
  initial begin
    rst         = 1'b1;
    start_i     = 1'b0;
    key_i       = '0;
    round_idx_i = '0;
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_fips_key();
    test_bounds();
    test_zero_key();
    test_start_during_expand();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
